fix_msg_framer: RTL and testbench

Byte-stream front end of the FIX parser. It hunts for the start of a message (`'8'`) and delimits the checksummed body. The body runs from `'8'` up to and including the SOH that precedes the `10=` trailer tag. The framer emits body bytes with start/end markers to the checksum stage, and routes the three ASCII checksum digits to the digit-to-integer converter. It sits directly upstream of the checksum block and validates trailer syntax and, optionally, message length.

---
 rtl/fix_pkg.sv | 22 ++
 rtl/fix_byte_window.sv | 35 +++
 rtl/fix_msg_framer.sv | 164 ++++++++++++++++
 tb/tb_fix_msg_framer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// FIX ASCII constants and framer state encoding, shared with the checksum stage.
package fix_pkg;

    localparam logic [7:0] SOH  = 8'h01;
    localparam logic [7:0] EQ   = 8'h3D;
    localparam logic [7:0] CH_0 = 8'h30;
    localparam logic [7:0] CH_1 = 8'h31;
    localparam logic [7:0] CH_8 = 8'h38;
    localparam logic [7:0] CH_9 = 8'h39;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BODY,
        ST_TRAILER,
        ST_TERM
    } framer_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/fix_byte_window.sv
// 3-deep byte shift window (w0 newest, w2 oldest) with per-slot valid bits.
// Updates one cycle after shift/flush; flush wins over shift; no backpressure.
module fix_byte_window (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] w0,
    output logic [7:0] w1,
    output logic [7:0] w2,
    output logic       v0,
    output logic       v1,
    output logic       v2
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            w0 <= 8'h00;
            w1 <= 8'h00;
            w2 <= 8'h00;
            v0 <= 1'b0;
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (shift) begin
            w0 <= din;
            w1 <= w0;
            w2 <= w1;
            v0 <= 1'b1;
            v1 <= v0;
            v2 <= v1;
        end
    end

endmodule

// File: rtl/fix_msg_framer.sv
// FIX framer: body bytes out 1 cycle after byte k+3, digits/ok/err 1 cycle after their byte.
// No backpressure (valid only). FIX_FRAMER_MAXLEN_EN adds the MAX_LEN body-length check.
module fix_msg_framer
    import fix_pkg::*;
#(
    parameter int MAX_LEN = 1024,
    parameter int LEN_W   = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic [7:0] body_data_o,
    output logic       body_valid_o,
    output logic       start_o,
    output logic       end_o,
    output logic [7:0] cks_data_o,
    output logic       cks_valid_o,
    output logic       cks_last_o,
    output logic       frame_ok_o,
    output logic       err_o
);

    if (LEN_W < $clog2(MAX_LEN + 1)) begin : g_len_w_check
        $error("LEN_W too narrow for MAX_LEN");
    end

    framer_state_t state;
    logic          started;
    logic          end_pend;
    logic [1:0]    dig_cnt;
    logic [7:0]    w0, w1, w2;
    logic          v0, v1, v2;
    logic          body_acc;
    logic          trailer_hit;
    logic          len_over;
    logic          win_shift;
    logic          win_flush;

    assign body_acc    = valid_i && (state == ST_BODY);
    assign trailer_hit = body_acc && (data_i == EQ) && v0 && v1 && v2 &&
                         (w0 == CH_0) && (w1 == CH_1) && (w2 == SOH);

`ifdef FIX_FRAMER_MAXLEN_EN
    logic [LEN_W-1:0] len_cnt;

    // len_cnt >= MAX_LEN means this byte would push the count past MAX_LEN.
    assign len_over = body_acc && !trailer_hit && (len_cnt >= LEN_W'(MAX_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            len_cnt <= '0;
        end else if (valid_i) begin
            if (state == ST_IDLE && data_i == CH_8) begin
                len_cnt <= LEN_W'(1);
            end else if (body_acc && !trailer_hit && !len_over) begin
                len_cnt <= len_cnt + 1'b1;
            end
        end
    end
`else
    assign len_over = 1'b0;
`endif

    assign win_shift = valid_i && (((state == ST_IDLE) && (data_i == CH_8)) ||
                                   (body_acc && !trailer_hit && !len_over));
    assign win_flush = trailer_hit || len_over;

    fix_byte_window u_window (
        .clk   (clk),
        .rst   (rst),
        .shift (win_shift),
        .flush (win_flush),
        .din   (data_i),
        .w0    (w0),
        .w1    (w1),
        .w2    (w2),
        .v0    (v0),
        .v1    (v1),
        .v2    (v2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            started      <= 1'b0;
            end_pend     <= 1'b0;
            dig_cnt      <= 2'd0;
            body_data_o  <= 8'h00;
            body_valid_o <= 1'b0;
            start_o      <= 1'b0;
            end_o        <= 1'b0;
            cks_data_o   <= 8'h00;
            cks_valid_o  <= 1'b0;
            cks_last_o   <= 1'b0;
            frame_ok_o   <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            body_valid_o <= 1'b0;
            start_o      <= 1'b0;
            cks_valid_o  <= 1'b0;
            cks_last_o   <= 1'b0;
            frame_ok_o   <= 1'b0;
            err_o        <= 1'b0;
            // end_o follows the last body byte even if the input stalls.
            end_o        <= end_pend;
            end_pend     <= 1'b0;
            if (valid_i) begin
                case (state)
                    ST_IDLE: begin
                        if (data_i == CH_8) begin
                            state   <= ST_BODY;
                            started <= 1'b0;
                        end
                    end
                    ST_BODY: begin
                        if (len_over) begin
                            err_o <= 1'b1;
                            state <= ST_IDLE;
                        end else if (trailer_hit) begin
                            body_data_o  <= w2;
                            body_valid_o <= 1'b1;
                            start_o      <= !started;
                            started      <= 1'b1;
                            end_pend     <= 1'b1;
                            dig_cnt      <= 2'd0;
                            state        <= ST_TRAILER;
                        end else if (v2) begin
                            body_data_o  <= w2;
                            body_valid_o <= 1'b1;
                            start_o      <= !started;
                            started      <= 1'b1;
                        end
                    end
                    ST_TRAILER: begin
                        if (is_digit(data_i)) begin
                            cks_data_o  <= data_i;
                            cks_valid_o <= 1'b1;
                            if (dig_cnt == 2'd2) begin
                                cks_last_o <= 1'b1;
                                state      <= ST_TERM;
                            end else begin
                                dig_cnt <= dig_cnt + 2'd1;
                            end
                        end else begin
                            err_o <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    ST_TERM: begin
                        if (data_i == SOH) begin
                            frame_ok_o <= 1'b1;
                        end else begin
                            err_o <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fix_msg_framer.sv
// Scoreboard bench for fix_msg_framer: expected output events (with cycle stamps)
// are queued as bytes are driven and compared against events captured from the DUT.
module tb_fix_msg_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic       valid_i;
    logic [7:0] body_data_o;
    logic       body_valid_o;
    logic       start_o;
    logic       end_o;
    logic [7:0] cks_data_o;
    logic       cks_valid_o;
    logic       cks_last_o;
    logic       frame_ok_o;
    logic       err_o;

    always #5 clk = ~clk;

    fix_msg_framer #(.MAX_LEN(8), .LEN_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .body_data_o  (body_data_o),
        .body_valid_o (body_valid_o),
        .start_o      (start_o),
        .end_o        (end_o),
        .cks_data_o   (cks_data_o),
        .cks_valid_o  (cks_valid_o),
        .cks_last_o   (cks_last_o),
        .frame_ok_o   (frame_ok_o),
        .err_o        (err_o)
    );

    // kind: 0 body (flag=start), 1 end, 2 digit (flag=last), 3 ok, 4 err, 5 stray marker
    typedef struct {
        int         kind;
        logic [7:0] dat;
        logic       flag;
        int         cyc;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    int         st[$];
    logic [7:0] pay[$];
    int         cyc      = 0;
    int         checks   = 0;
    int         failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (body_valid_o)              obs_q.push_back('{0, body_data_o, start_o, cyc});
        if (end_o)                     obs_q.push_back('{1, 8'h00, 1'b0, cyc});
        if (cks_valid_o)               obs_q.push_back('{2, cks_data_o, cks_last_o, cyc});
        if (frame_ok_o)                obs_q.push_back('{3, 8'h00, 1'b0, cyc});
        if (err_o)                     obs_q.push_back('{4, 8'h00, 1'b0, cyc});
        if (start_o && !body_valid_o)  obs_q.push_back('{5, 8'h00, 1'b0, cyc});
        if (cks_last_o && !cks_valid_o) obs_q.push_back('{5, 8'h01, 1'b0, cyc});
    end

    // Called just after a negedge; the byte is accepted at the next posedge.
    task automatic drive(input logic [7:0] b, input int idle);
        data_i  = b;
        valid_i = 1'b1;
        st.push_back(cyc + 1);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] d, input logic f, input int c);
        exp_q.push_back('{kind, d, f, c});
    endtask

    // Drives pay + "10=" + three digits + SOH; body byte k is due one cycle after input k+3.
    task automatic send_frame(input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input int idle);
        int base;
        int len;
        base = st.size();
        len  = pay.size();
        foreach (pay[i]) drive(pay[i], idle);
        drive(8'h31, idle);
        drive(8'h30, idle);
        drive(8'h3D, idle);
        drive(d0, idle);
        drive(d1, idle);
        drive(d2, idle);
        drive(8'h01, idle);
        for (int k = 0; k < len; k++) expect_ev(0, pay[k], k == 0, st[base + k + 3]);
        expect_ev(1, 8'h00, 1'b0, st[base + len + 2] + 1);
        expect_ev(2, d0, 1'b0, st[base + len + 3]);
        expect_ev(2, d1, 1'b0, st[base + len + 4]);
        expect_ev(2, d2, 1'b1, st[base + len + 5]);
        expect_ev(3, 8'h00, 1'b0, st[base + len + 6]);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({body_valid_o, start_o, end_o, cks_valid_o, cks_last_o, frame_ok_o, err_o} !== 7'd0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000000",
                     {body_valid_o, start_o, end_o, cks_valid_o, cks_last_o, frame_ok_o, err_o});
        end
        checks++;
        if ({body_data_o, cks_data_o} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data got=%h want=0000", {body_data_o, cks_data_o});
        end
        rst = 1'b0;
        drive(8'h31, 0);
        drive(8'h30, 0);
        drive(8'h3D, 0);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL reset_idle_10eq events=%0d want=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_minimal;
        ev_t e, o;
        pay = '{8'h38, 8'h3D, 8'h46, 8'h01};
        send_frame(8'h31, 8'h32, 8'h33, 0);
        repeat (6) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL minimal missing kind=%0d want dat=%h flag=%b cyc=%0d", e.kind, e.dat, e.flag, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.dat !== e.dat || o.flag !== e.flag || o.cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL minimal got kind=%0d dat=%h flag=%b cyc=%0d want kind=%0d dat=%h flag=%b cyc=%0d",
                             o.kind, o.dat, o.flag, o.cyc, e.kind, e.dat, e.flag, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL minimal extra events=%0d want=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_stalls;
        ev_t e, o;
        pay = '{8'h38, 8'h3D, 8'h46, 8'h01};
        send_frame(8'h31, 8'h32, 8'h33, 1);
        repeat (6) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL stalls missing kind=%0d want dat=%h flag=%b cyc=%0d", e.kind, e.dat, e.flag, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.dat !== e.dat || o.flag !== e.flag || o.cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL stalls got kind=%0d dat=%h flag=%b cyc=%0d want kind=%0d dat=%h flag=%b cyc=%0d",
                             o.kind, o.dat, o.flag, o.cyc, e.kind, e.dat, e.flag, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL stalls extra events=%0d want=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_bad_trailer;
        ev_t e, o;
        int  base;
        pay  = '{8'h38, 8'h3D, 8'h46, 8'h01};
        base = st.size();
        foreach (pay[i]) drive(pay[i], 0);
        drive(8'h31, 0);
        drive(8'h30, 0);
        drive(8'h3D, 0);
        drive(8'h31, 0);
        drive(8'h41, 0);
        drive(8'h33, 0);
        for (int k = 0; k < 4; k++) expect_ev(0, pay[k], k == 0, st[base + k + 3]);
        expect_ev(1, 8'h00, 1'b0, st[base + 6] + 1);
        expect_ev(2, 8'h31, 1'b0, st[base + 7]);
        expect_ev(4, 8'h00, 1'b0, st[base + 8]);
        send_frame(8'h37, 8'h38, 8'h39, 0);
        repeat (6) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL bad_trailer missing kind=%0d want dat=%h flag=%b cyc=%0d", e.kind, e.dat, e.flag, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.dat !== e.dat || o.flag !== e.flag || o.cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL bad_trailer got kind=%0d dat=%h flag=%b cyc=%0d want kind=%0d dat=%h flag=%b cyc=%0d",
                             o.kind, o.dat, o.flag, o.cyc, e.kind, e.dat, e.flag, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL bad_trailer extra events=%0d want=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_decoy;
        ev_t e, o;
        pay = '{8'h38, 8'h01, 8'h31, 8'h30, 8'h58, 8'h01};
        send_frame(8'h34, 8'h35, 8'h36, 0);
        repeat (6) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL decoy missing kind=%0d want dat=%h flag=%b cyc=%0d", e.kind, e.dat, e.flag, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.dat !== e.dat || o.flag !== e.flag || o.cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL decoy got kind=%0d dat=%h flag=%b cyc=%0d want kind=%0d dat=%h flag=%b cyc=%0d",
                             o.kind, o.dat, o.flag, o.cyc, e.kind, e.dat, e.flag, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL decoy extra events=%0d want=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_overlong;
        ev_t e, o;
        int  base;
        pay  = '{8'h38, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
        base = st.size();
        foreach (pay[i]) drive(pay[i], 0);
`ifdef FIX_FRAMER_MAXLEN_EN
        for (int k = 0; k < 5; k++) expect_ev(0, pay[k], k == 0, st[base + k + 3]);
        expect_ev(4, 8'h00, 1'b0, st[base + 8]);
`else
        for (int k = 0; k < 6; k++) expect_ev(0, pay[k], k == 0, st[base + k + 3]);
`endif
        repeat (6) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL overlong missing kind=%0d want dat=%h flag=%b cyc=%0d", e.kind, e.dat, e.flag, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.dat !== e.dat || o.flag !== e.flag || o.cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL overlong got kind=%0d dat=%h flag=%b cyc=%0d want kind=%0d dat=%h flag=%b cyc=%0d",
                             o.kind, o.dat, o.flag, o.cyc, e.kind, e.dat, e.flag, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL overlong extra events=%0d want=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_body;
        ev_t e, o;
        int  base;
        pay  = '{8'h38, 8'h41, 8'h42, 8'h43, 8'h44};
        base = st.size();
        foreach (pay[i]) drive(pay[i], 0);
        expect_ev(0, 8'h38, 1'b1, st[base + 3]);
        expect_ev(0, 8'h41, 1'b0, st[base + 4]);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pay = '{8'h38, 8'h5A, 8'h01};
        send_frame(8'h30, 8'h39, 8'h35, 0);
        repeat (6) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL reset_mid missing kind=%0d want dat=%h flag=%b cyc=%0d", e.kind, e.dat, e.flag, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.dat !== e.dat || o.flag !== e.flag || o.cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL reset_mid got kind=%0d dat=%h flag=%b cyc=%0d want kind=%0d dat=%h flag=%b cyc=%0d",
                             o.kind, o.dat, o.flag, o.cyc, e.kind, e.dat, e.flag, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL reset_mid extra events=%0d want=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back;
        ev_t e, o;
        pay = '{8'h38, 8'h3D, 8'h46, 8'h01};
        send_frame(8'h31, 8'h32, 8'h33, 0);
        pay = '{8'h38, 8'h3D, 8'h38, 8'h3D, 8'h01};
        send_frame(8'h32, 8'h30, 8'h31, 0);
        repeat (6) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL back_to_back missing kind=%0d want dat=%h flag=%b cyc=%0d", e.kind, e.dat, e.flag, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.dat !== e.dat || o.flag !== e.flag || o.cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL back_to_back got kind=%0d dat=%h flag=%b cyc=%0d want kind=%0d dat=%h flag=%b cyc=%0d",
                             o.kind, o.dat, o.flag, o.cyc, e.kind, e.dat, e.flag, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL back_to_back extra events=%0d want=0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        test_reset;
        test_minimal;
        test_stalls;
        test_bad_trailer;
        test_decoy;
        test_overlong;
        test_reset_mid_body;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
